// File: rtl/bitrev_pingpong_if.sv
// bitrev_pingpong_if: natural-order input stream with frame config, and reordered output stream
interface bitrev_pingpong_if #(
  parameter int KMAX = 10,
  parameter int DW = 32,
  localparam int KW = $clog2(KMAX + 1)
);
  logic [KW-1:0] cfg_k_i;
  logic cfg_mode_i;
  logic valid_i;
  logic [DW-1:0] data_i;
  logic ready_o;
  logic valid_o;
  logic [DW-1:0] data_o;
  logic last_o;
  logic ready_i;
  modport slave (
    input cfg_k_i, cfg_mode_i, valid_i, data_i, ready_i,
    output ready_o, valid_o, data_o, last_o
  );
  modport master (
    output cfg_k_i, cfg_mode_i, valid_i, data_i, ready_i,
    input ready_o, valid_o, data_o, last_o
  );
endinterface

// File: rtl/bitrev_pingpong.sv
// bitrev_pingpong: ping-pong bank reorder stage, one bank fills naturally while the other drains bit-reversed
module bitrev_pingpong #(
  parameter int KMAX = 10,
  parameter int DW = 32,
  localparam int KW = $clog2(KMAX + 1)
) (
  input logic clk_i,
  input logic rst_ni,
  bitrev_pingpong_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_t;
  localparam logic [KMAX:0] ONE = 1;
  localparam logic [KW-1:0] KTOP = KW'(KMAX);
  logic [DW-1:0] mem [2][1<<KMAX];
  bank_t st [2];
  logic [KW-1:0] bk [2];
  logic bm [2];
  logic wb, rb, rdy, wr, wlast, load, rlast;
  logic [KMAX-1:0] wc, rc, rfull, raddr;
  logic [KW-1:0] kin, wk, rk;
  always_comb begin
    kin = (bus.cfg_k_i == '0 || bus.cfg_k_i > KTOP) ? KTOP : bus.cfg_k_i;
    wk = (wc == '0) ? kin : bk[wb];
    wlast = {1'b0, wc} == (ONE << wk) - ONE;
    rdy = rst_ni && (st[wb] == EMPTY || st[wb] == FILLING);
    wr = bus.valid_i && rdy;
    rk = bk[rb];
    for (int i = 0; i < KMAX; i++) rfull[i] = rc[KMAX-1-i];
    // full-width reversal shifted down leaves only the low k bits reversed
    raddr = bm[rb] ? rc : rfull >> (KTOP - rk);
    rlast = {1'b0, rc} == (ONE << rk) - ONE;
    load = (!bus.valid_o || bus.ready_i) && (st[rb] == FULL || st[rb] == DRAINING);
  end
  assign bus.ready_o = rdy;
  always_ff @(posedge clk_i) if (wr) mem[wb][wc] <= bus.data_i;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb <= 1'b0;
      rb <= 1'b0;
      wc <= '0;
      rc <= '0;
      bus.valid_o <= 1'b0;
      bus.last_o <= 1'b0;
      bus.data_o <= '0;
      for (int i = 0; i < 2; i++) begin
        st[i] <= EMPTY;
        bk[i] <= KTOP;
        bm[i] <= 1'b0;
      end
    end else begin
      if (wr) begin
        if (wc == '0) begin
          bk[wb] <= kin;
          bm[wb] <= bus.cfg_mode_i;
        end
        if (wlast) begin
          st[wb] <= FULL;
          wc <= '0;
          wb <= ~wb;
        end else begin
          st[wb] <= FILLING;
          wc <= wc + 1'b1;
        end
      end
      // write and read sides never share a bank, so both updates can land on one edge
      if (load) begin
        bus.data_o <= mem[rb][raddr];
        bus.valid_o <= 1'b1;
        bus.last_o <= rlast;
        if (rlast) begin
          st[rb] <= EMPTY;
          rc <= '0;
          rb <= ~rb;
        end else begin
          st[rb] <= DRAINING;
          rc <= rc + 1'b1;
        end
      end else if (bus.ready_i) begin
        bus.valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_bitrev_pingpong.sv
// tb_bitrev_pingpong: randomized frames checked against a queue-based reorder model
module tb_bitrev_pingpong;
  localparam int KMAX = 10;
  localparam int DW = 32;
  localparam int KW = $clog2(KMAX + 1);
  localparam int BOUND = 3000;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  int rdy_pct = 100;
  int consumed = 0;
  bit chk_rdy = 0;
  logic [DW:0] exp_q [$];
  bitrev_pingpong_if #(.KMAX(KMAX), .DW(DW)) bus ();
  bitrev_pingpong #(.KMAX(KMAX), .DW(DW)) dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int brev(input int v, input int k);
    int r = 0;
    for (int b = 0; b < k; b++) r = r * 2 + ((v >> b) & 1);
    return r;
  endfunction
  task automatic send_frame(input int k, input bit mode, input bit seq, input int base, input int gap_pct);
    int keff = (k == 0 || k > KMAX) ? KMAX : k;
    int n = 1 << keff;
    logic [DW-1:0] d [];
    d = new[n];
    for (int i = 0; i < n; i++) d[i] = seq ? DW'(base + i) : DW'($urandom);
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        @(negedge clk_i);
        bus.valid_i = 1'b0;
        bus.data_i = $urandom;
        bus.cfg_k_i = KW'($urandom_range(0, 15));
      end
      @(negedge clk_i);
      bus.valid_i = 1'b1;
      bus.data_i = d[i];
      bus.cfg_k_i = (i == 0) ? KW'(k) : KW'($urandom_range(0, 15));
      bus.cfg_mode_i = (i == 0) ? mode : 1'($urandom_range(0, 1));
      if (chk_rdy) check("ready_hold", bus.ready_o, 1);
      for (int w = 0; !bus.ready_o && w < BOUND; w++) @(negedge clk_i);
      if (!bus.ready_o) check("in_timeout", bus.ready_o, 1);
    end
    for (int j = 0; j < n; j++) exp_q.push_back({j == n - 1, d[mode ? j : brev(j, keff)]});
  endtask
  task automatic idle();
    @(negedge clk_i);
    bus.valid_i = 1'b0;
  endtask
  task automatic drain();
    for (int w = 0; exp_q.size() != 0 && w < 5 * BOUND; w++) @(negedge clk_i);
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    repeat (4) @(negedge clk_i);
  endtask
  initial begin
    bit stall = 0;
    logic [DW-1:0] pd;
    logic pl;
    logic [DW:0] e;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        stall = 0;
      end else begin
        if (stall) begin
          check("hold_valid", bus.valid_o, 1);
          check("hold_data", bus.data_o, pd);
          check("hold_last", bus.last_o, pl);
        end
        bus.ready_i = $urandom_range(0, 99) < rdy_pct;
        if (bus.valid_o && bus.ready_i) begin
          if (exp_q.size() == 0) check("spurious_valid", bus.valid_o, 0);
          else begin
            e = exp_q.pop_front();
            check("data", bus.data_o, e[DW-1:0]);
            check("last", bus.last_o, e[DW]);
            consumed++;
          end
        end
        stall = bus.valid_o && !bus.ready_i;
        pd = bus.data_o;
        pl = bus.last_o;
      end
    end
  end
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [DW-1:0] d0;
    int c0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.data_i = '0;
    bus.cfg_k_i = '0;
    bus.cfg_mode_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_ready", bus.ready_o, 0);
    check("rst_valid", bus.valid_o, 0);
    check("rst_data", bus.data_o, 0);
    check("rst_last", bus.last_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1 check("rel_ready", bus.ready_o, 1);
    send_frame(3, 0, 1, 0, 0);
    @(posedge clk_i);
    #1 check("lat_early", bus.valid_o, 0);
    @(negedge clk_i);
    bus.valid_i = 1'b0;
    @(posedge clk_i);
    #1 check("lat_valid", bus.valid_o, 1);
    check("lat_data", bus.data_o, 0);
    drain();
    chk_rdy = 1;
    fork
      begin
        for (int f = 0; f < 4; f++) send_frame(KMAX, 0, 1, f << KMAX, 0);
        idle();
      end
      begin
        for (int w = 0; !bus.valid_o && w < BOUND; w++) @(negedge clk_i);
        for (int i = 0; i < 4 << KMAX; i++) begin
          check("gapless", bus.valid_o, 1);
          @(negedge clk_i);
        end
      end
    join
    chk_rdy = 0;
    drain();
    send_frame(4, 1, 1, 0, 0);
    idle();
    drain();
    rdy_pct = 0;
    @(negedge clk_i);
    send_frame(3, 0, 0, 0, 0);
    send_frame(3, 0, 0, 0, 0);
    @(negedge clk_i);
    bus.valid_i = 1'b0;
    check("bp_ready_low", bus.ready_o, 0);
    check("bp_valid", bus.valid_o, 1);
    check("bp_front", bus.data_o, exp_q[0][DW-1:0]);
    d0 = bus.data_o;
    repeat (4) @(negedge clk_i);
    check("bp_hold", bus.data_o, d0);
    fork
      send_frame(3, 0, 0, 0, 0);
      begin
        rdy_pct = 50;
        for (int w = 0; !bus.ready_o && w < BOUND; w++) @(negedge clk_i);
        check("rise_last", bus.last_o, 1);
        check("rise_valid", bus.valid_o, 1);
      end
    join
    idle();
    drain();
    rdy_pct = 70;
    send_frame(3, 0, 0, 0, 20);
    send_frame(0, 0, 0, 0, 10);
    send_frame(13, 1, 0, 0, 10);
    idle();
    drain();
    rdy_pct = 30;
    send_frame(3, 0, 0, 0, 0);
    idle();
    c0 = consumed;
    for (int w = 0; consumed < c0 + 2 && w < BOUND; w++) @(negedge clk_i);
    check("mid_drain", bus.valid_o, 1);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check("mrst_valid", bus.valid_o, 0);
    check("mrst_ready", bus.ready_o, 0);
    check("mrst_data", bus.data_o, 0);
    check("mrst_last", bus.last_o, 0);
    exp_q.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    rdy_pct = 100;
    send_frame(2, 0, 1, 0, 0);
    idle();
    drain();
    for (int f = 0; f < 12; f++) begin
      rdy_pct = $urandom_range(20, 100);
      send_frame($urandom_range(1, 5), 1'($urandom_range(0, 1)), 0, 0, 25);
    end
    idle();
    rdy_pct = 100;
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bitrev_pingpong.md
# bitrev_pingpong

Streaming bit-reversal reorder stage with two ping-pong frame banks, runtime-selectable frame length and a per-frame reorder mode. One bank fills in natural order while the other drains in reordered order, so continuous frames pass at one word per cycle with no stall. It sits between the sample front-end and the FFT butterfly pipeline. It replaces the single-frame `bitrev` core, which could not accept a new frame until the previous one had drained.

## Interface
- `KMAX`, 10: log2 of the maximum frame length. Each bank holds 2^KMAX words.
- `DW`, 32: data word width.
- `KW`, $clog2(KMAX+1): width of `cfg_k_i` (derived; do not override).

- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `cfg_k_i`  in  KW  log2 frame length for the next frame.
- `cfg_mode_i`  in  1  0 = bit-reversed output, 1 = natural order (pass-through framing).
- `valid_i`  in  1  input word valid.
- `data_i`  in  DW  input word.
- `ready_o`  out  1  input accepted when `valid_i && ready_o`.
- `valid_o`  out  1  output word valid (registered).
- `data_o`  out  DW  output word (registered).
- `last_o`  out  1  high with the final word of a frame (registered).
- `ready_i`  in  1  output accepted when `valid_o && ready_i`.

## Operation
- Storage: 2 banks × 2^KMAX × DW flop array with combinational read. Each bank has a state EMPTY, FILLING, FULL or DRAINING, plus a latched k (KW bits) and a latched mode (1 bit).
- Write side:
  - Write-bank pointer `wb` (1 bit) and write counter `wc` (KMAX bits).
  - `ready_o = (state[wb] == EMPTY) || (state[wb] == FILLING)`.
  - On an accepted word with `wc == 0`, latch `cfg_k_i` and `cfg_mode_i` into bank `wb` and set it to FILLING.
  - Clamp: a `cfg_k_i` of 0 or greater than KMAX latches as KMAX.
  - Every accepted word is stored at address `wc`, then `wc` increments.
  - When `wc == 2^k - 1` on an accepted word: the bank becomes FULL, `wc` returns to 0 and `wb` toggles.
  - Config inputs are ignored while `wc != 0`.
- Read side:
  - Read-bank pointer `rb` and read counter `rc` (KMAX bits).
  - The output register loads when `(!valid_o || ready_i)` and `state[rb]` is FULL or DRAINING. Otherwise it holds its value.
  - A FULL bank becomes DRAINING on its first load.
  - Read address: in mode 0, the low k bits of `rc` bit-reversed (upper bits 0); in mode 1, `rc`.
  - Each load sets `last_o = (rc == 2^k - 1)`.
  - On the last load of a frame, the bank becomes EMPTY in the same edge, `rc` returns to 0 and `rb` toggles.
  - If no load occurs and `ready_i` is high, `valid_o` clears.
- The write and read sides always address different banks. A bank is never written while FULL or DRAINING.
- Arithmetic: counters compare against `(1<<k)-1` computed in KMAX+1 bits. Bit reversal covers only bits [k-1:0].

## Timing
- Reset values: `ready_o=0` while `rst_ni` is low, then 1 on the first cycle after release; `valid_o=0`; `data_o=0`; `last_o=0`. All banks EMPTY; `wb`, `rb`, `wc`, `rc` all 0.
- Latency: if the last word of a frame is accepted at edge t, the first reordered word is in `data_o` after edge t+1, provided the read side is idle.
- Throughput: with `valid_i` and `ready_i` held high, frames stream gaplessly. `ready_o` never drops, because the draining bank becomes EMPTY on the same edge that the opposite bank becomes FULL.
- Backpressure: `data_o` and `last_o` are stable while `valid_o && !ready_i`. If both banks are FULL or DRAINING, `ready_o` is 0.
- A bank transitioning FILLING→FULL and the other bank DRAINING→EMPTY on the same edge is legal; both updates take effect.
- Reset asserted mid-operation discards all frames immediately. Outputs take their reset values asynchronously.
- Frame length k=1: 2-word frames. Reversal of one bit is identity.

## Test plan
- Reset, then send frame k=3, mode 0, data 0..7 with `ready_i=1` → output 0,4,2,6,1,5,3,7; `last_o` only on 7; first `valid_o` one cycle after the input word 7 is accepted.
- Four back-to-back KMAX frames (data = global index), `valid_i=ready_i=1` → `ready_o` stays 1 after reset release; output has no gaps; each frame's word i equals frame_base + bitrev_K(i).
- Frame k=4, mode 1, data 0..15 → output 0..15 in order; `last_o` on 15.
- `ready_i=0` while sending three k=3 frames → `ready_o` falls after the 16th word; raise `ready_i` → frames 1 and 2 reordered correctly, `ready_o` rises once the first bank drains; `data_o` is held during stalls.
- `cfg_k_i` changed from 3 to 5 mid-frame, and `cfg_k_i=0` on a later frame → first frame is 8 words; later frame is 2^KMAX words.
- Reset pulse mid-drain of a k=3 frame → `valid_o` drops immediately; a following k=2 frame with data 0..3 outputs 0,2,1,3.
